fifo_native_to_axis_master: RTL and testbench
=============================================

// Module: fifo_native_to_axis_master
// PURPOSE
//  Read-side adapter: drains a native FIFO read port and drives an AXI-Stream master.
//  It is the counterpart of the axis-to-native writer. It sits after the fifo_type_1
//  read domain and before the downstream AXIS consumer.
//  Native word packs {tlast, tdest, tid, tdata}. A 2-entry output buffer (head + skid)
//  gives 1 word/cycle at continuous tready while tvalid/payload stay AXIS-stable.
// PARAMETERS
//  TDataWidth            32      tdata width in bits
//  TidWidth              8       tid width in bits
//  TdestWidth            8       tdest width in bits
//  FirstWordFallThrough  "true"  "true": rdata valid while !fifo_rempty; "false": rdata valid 1 cycle after rinc
//  NativeWidth (local)   TDataWidth+TidWidth+TdestWidth+1
// PORTS
//  m_axis_aclk    in   1            clock (only clock)
//  m_axis_arstn   in   1            reset, asynchronous, active-low
//  fifo_rdata     in   NativeWidth  FIFO read data {tlast,tdest,tid,tdata} (MSB..LSB)
//  fifo_rempty    in   1            FIFO empty flag
//  fifo_rinc      out  1            FIFO read/pop strobe (combinational)
//  m_axis_tid     out  TidWidth     stream id of head word
//  m_axis_tdest   out  TdestWidth   destination of head word
//  m_axis_tdata   out  TDataWidth   payload of head word
//  m_axis_tvalid  out  1            head word valid
//  m_axis_tlast   out  1            packet boundary of head word
//  m_axis_tready  in   1            downstream accepts
// BEHAVIOUR
//  Reset (arstn low, async): tvalid=0, tdata/tid/tdest/tlast=0, count=0, inflight=0,
//   skid cleared. fifo_rinc=0 while in reset. Buffered words are discarded.
//  pop = tvalid & tready. Data/sideband outputs are registered from the head entry.
//  count in {0,1,2} = words held. inflight (FWF="false" only) = rinc issued last cycle.
//  fifo_rinc = !fifo_rempty & ((count + inflight - pop) < 2). The buffer never overflows.
//  Capture point: FWF="true" captures fifo_rdata in the same cycle as rinc.
//   FWF="false" captures when inflight=1.
//  Head/skid update per cycle (cap = word captured this cycle):
//   cap & !pop: count 0 -> head; count 1 -> skid; count 2 cannot occur.
//   !cap & pop: skid -> head if count=2; else tvalid falls.
//   cap & pop: count 1 -> head<=new; count 2 -> head<=skid, skid<=new; count unchanged.
//  tvalid = (count != 0), registered. Once tvalid=1, payload stays stable until pop.
//   tvalid never drops without pop. tready is ignored while tvalid=0.
//  Latency, rempty falling at edge N: FWF="true" rinc in cycle N, tvalid at N+1.
//   FWF="false" rinc in cycle N, capture at N+1, tvalid at N+2.
//  Throughput: 1 word/cycle sustained with tready=1 and FIFO non-empty (both modes).
//  Backpressure: with tready=0, exactly 2 words are held and rinc stays 0.
//   FWF="false" still accepts an in-flight word: the rinc condition already counts it.
//  Empty FIFO: rinc=0. tvalid drops only after the last held word pops.
//  tlast is carried unchanged. No packet-level state; the block never reorders words.
// TESTING
//  T_RESET: hold arstn=0, rempty=0 -> tvalid=0, rinc=0, all outputs 0. Release -> first rinc next cycle.
//  T_SINGLE: one word 0xCAFE0001 (tid=3,tdest=5,tlast=1), tready=1 -> tvalid 1 cycle (FWF=true).
//   AXIS fields match; rinc pulsed exactly once.
//  T_STREAM: 16 words 0..15, tready=1 -> 16 consecutive tvalid&tready cycles, in order, no bubbles
//   after the first (both FWF values).
//  T_BACKPRESSURE: FIFO holds 8 words, tready=0 for 10 cycles -> exactly 2 rinc, tdata=word0 stable.
//   Then tready=1 -> words 0..7 out in order, none lost or duplicated.
//  T_RANDOM_READY: 64 words, tready random 50%, rempty toggling -> output sequence equals input sequence.
//   Payload never changes while tvalid&!tready.
//  T_RESET_MID: reset asserted with count=2 -> tvalid=0 immediately (async). After release,
//   only words still in the FIFO appear.

Source files
------------

// File: rtl/fifo_native_to_axis_master_if.sv
// fifo_native_to_axis_master_if: AXI-Stream bus between the native-FIFO reader and its downstream consumer
interface fifo_native_to_axis_master_if #(
    parameter int TDataWidth = 32,
    parameter int TidWidth   = 8,
    parameter int TdestWidth = 8
);
    logic [TDataWidth-1:0] tdata;
    logic [TidWidth-1:0]   tid;
    logic [TdestWidth-1:0] tdest;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;
    modport master (output tdata, tid, tdest, tvalid, tlast, input tready);
    modport slave (input tdata, tid, tdest, tvalid, tlast, output tready);
endinterface

// File: rtl/fifo_native_to_axis_master.sv
// fifo_native_to_axis_master: drains a native FIFO read port into an AXI-Stream master via a head/skid buffer
module fifo_native_to_axis_master #(
    parameter int    TDataWidth           = 32,
    parameter int    TidWidth             = 8,
    parameter int    TdestWidth           = 8,
    parameter string FirstWordFallThrough = "true",
    localparam int   NativeWidth          = TDataWidth + TidWidth + TdestWidth + 1
) (
    input  logic                         m_axis_aclk,
    input  logic                         m_axis_arstn,
    input  logic [NativeWidth-1:0]       fifo_rdata,
    input  logic                         fifo_rempty,
    output logic                         fifo_rinc,
    fifo_native_to_axis_master_if.master m_axis
);
    localparam bit Fwf = (FirstWordFallThrough == "true");
    logic [1:0]             count;
    logic [1:0]             occ;
    logic                   inflight;
    logic                   tvalid_q;
    logic                   pop;
    logic                   cap;
    logic [NativeWidth-1:0] head;
    logic [NativeWidth-1:0] skid;
    assign pop = tvalid_q & m_axis.tready;
    // occupancy after this cycle's pop, counting a read still in flight so the buffer never overflows
    assign occ = count + {1'b0, inflight} - {1'b0, pop};
    assign fifo_rinc = m_axis_arstn & ~fifo_rempty & ~occ[1];
    assign cap = Fwf ? fifo_rinc : inflight;
    assign {m_axis.tlast, m_axis.tdest, m_axis.tid, m_axis.tdata} = head;
    assign m_axis.tvalid = tvalid_q;
    // head/skid buffer: capture new words behind the head, shift skid forward on pop
    always_ff @(posedge m_axis_aclk or negedge m_axis_arstn) begin
        if (!m_axis_arstn) begin
            count    <= 2'd0;
            inflight <= 1'b0;
            tvalid_q <= 1'b0;
            head     <= '0;
            skid     <= '0;
        end else begin
            inflight <= Fwf ? 1'b0 : fifo_rinc;
            if (cap && !pop) begin
                if (count == 2'd0) head <= fifo_rdata;
                else skid <= fifo_rdata;
                count    <= count + 2'd1;
                tvalid_q <= 1'b1;
            end else if (!cap && pop) begin
                if (count == 2'd2) head <= skid;
                count    <= count - 2'd1;
                tvalid_q <= (count == 2'd2);
            end else if (cap && pop) begin
                head <= (count == 2'd2) ? skid : fifo_rdata;
                if (count == 2'd2) skid <= fifo_rdata;
            end
        end
    end
endmodule

// File: tb/tb_fifo_native_to_axis_master.sv
// tb_fifo_native_to_axis_master: checks both FWF modes side by side against a FIFO model and an in-order scoreboard
module tb_fifo_native_to_axis_master;
    localparam int DW  = 32;
    localparam int IW  = 8;
    localparam int DSW = 8;
    localparam int NW  = DW + IW + DSW + 1;

    typedef struct {
        logic [31:0]   data;
        logic [7:0]    id;
        logic [7:0]    dest;
        logic          last;
        logic [NW-1:0] exp_word;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tready = 1'b0;
    logic hold = 1'b0;
    always #5 clk = ~clk;

    logic [NW-1:0] mem [512];
    int wp = 0;
    int rp0 = 0;
    int rp1 = 0;
    logic rempty0, rempty1, rinc0, rinc1;
    logic [NW-1:0] rd0, rd1, p0, p1;
    logic [NW-1:0] exp0 [$];
    logic [NW-1:0] exp1 [$];
    int n_checks = 0;
    int n_errors = 0;

    fifo_native_to_axis_master_if #(.TDataWidth(DW), .TidWidth(IW), .TdestWidth(DSW)) ax0 ();
    fifo_native_to_axis_master_if #(.TDataWidth(DW), .TidWidth(IW), .TdestWidth(DSW)) ax1 ();

    assign ax0.tready = tready;
    assign ax1.tready = tready;
    assign rempty0 = hold | (rp0 >= wp);
    assign rempty1 = hold | (rp1 >= wp);
    assign rd0 = mem[rp0[8:0]];
    assign p0 = {ax0.tlast, ax0.tdest, ax0.tid, ax0.tdata};
    assign p1 = {ax1.tlast, ax1.tdest, ax1.tid, ax1.tdata};

    fifo_native_to_axis_master #(.TDataWidth(DW), .TidWidth(IW), .TdestWidth(DSW), .FirstWordFallThrough("true")) dut0 (
        .m_axis_aclk(clk), .m_axis_arstn(rst_n), .fifo_rdata(rd0), .fifo_rempty(rempty0),
        .fifo_rinc(rinc0), .m_axis(ax0));
    fifo_native_to_axis_master #(.TDataWidth(DW), .TidWidth(IW), .TdestWidth(DSW), .FirstWordFallThrough("false")) dut1 (
        .m_axis_aclk(clk), .m_axis_arstn(rst_n), .fifo_rdata(rd1), .fifo_rempty(rempty1),
        .fifo_rinc(rinc1), .m_axis(ax1));

    // FIFO model: FWF read port advances on rinc; standard read port registers data one cycle after rinc
    always @(posedge clk) begin
        if (rinc0) rp0 <= rp0 + 1;
        if (rinc1) begin
            rd1 <= mem[rp1[8:0]];
            rp1 <= rp1 + 1;
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(logic [NW-1:0] w);
        mem[wp[8:0]] = w;
        wp++;
        exp0.push_back(w);
        exp1.push_back(w);
    endtask

    task automatic rebuild();
        exp0.delete();
        exp1.delete();
        for (int i = rp0; i < wp; i++) exp0.push_back(mem[i[8:0]]);
        for (int i = rp1; i < wp; i++) exp1.push_back(mem[i[8:0]]);
    endtask

    task automatic drain(string name, int lim);
        for (int c = 0; c < lim && (exp0.size() != 0 || exp1.size() != 0); c++) @(posedge clk);
        #1;
        check({name, "_left0"}, 64'(exp0.size()), 0);
        check({name, "_left1"}, 64'(exp1.size()), 0);
    endtask

    // output monitor: in-order scoreboard plus AXIS stability while stalled
    logic st0 = 1'b0;
    logic st1 = 1'b0;
    logic [NW-1:0] prev0, prev1;
    always @(negedge clk) begin
        if (!rst_n) begin
            st0 <= 1'b0;
            st1 <= 1'b0;
        end else begin
            if (st0) check("stable0", {ax0.tvalid, p0}, {1'b1, prev0});
            if (st1) check("stable1", {ax1.tvalid, p1}, {1'b1, prev1});
            if (ax0.tvalid && tready) begin
                check("avail0", 64'(exp0.size() != 0), 1);
                if (exp0.size() != 0) check("order0", p0, exp0.pop_front());
            end
            if (ax1.tvalid && tready) begin
                check("avail1", 64'(exp1.size() != 0), 1);
                if (exp1.size() != 0) check("order1", p1, exp1.pop_front());
            end
            st0 <= ax0.tvalid & ~tready;
            st1 <= ax1.tvalid & ~tready;
            prev0 <= p0;
            prev1 <= p1;
        end
    end

    vec_t vecs [4];
    int r0, r1, n0, n1, f0, f1, l0, l1, pushed;
    logic [NW-1:0] w0;

    initial begin
        vecs[0] = '{32'hCAFE0001, 8'h03, 8'h05, 1'b1, {1'b1, 8'h05, 8'h03, 32'hCAFE0001}};
        vecs[1] = '{32'h00000000, 8'h00, 8'h00, 1'b0, {1'b0, 8'h00, 8'h00, 32'h00000000}};
        vecs[2] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 1'b1, {1'b1, 8'hFF, 8'hFF, 32'hFFFFFFFF}};
        vecs[3] = '{32'h12345678, 8'hA5, 8'h5A, 1'b0, {1'b0, 8'h5A, 8'hA5, 32'h12345678}};

        // reset with a non-empty FIFO
        push({1'b0, 8'h11, 8'h22, 32'hA0});
        push({1'b1, 8'h33, 8'h44, 32'hA1});
        repeat (3) @(negedge clk);
        check("rst_tvalid0", ax0.tvalid, 0);
        check("rst_tvalid1", ax1.tvalid, 0);
        check("rst_rinc0", rinc0, 0);
        check("rst_rinc1", rinc1, 0);
        check("rst_out0", p0, 0);
        check("rst_out1", p1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_rinc0", rinc0, 1);
        check("rel_rinc1", rinc1, 1);
        tready = 1'b1;
        drain("rst", 20);

        // single words: latency 1 (FWF) and 2 (registered read), one rinc each
        for (int v = 0; v < 4; v++) begin
            @(posedge clk); #1;
            r0 = rp0;
            r1 = rp1;
            push({vecs[v].last, vecs[v].dest, vecs[v].id, vecs[v].data});
            @(negedge clk);
            check("single_pre_tvalid0", ax0.tvalid, 0);
            check("single_rinc0", rinc0, 1);
            check("single_rinc1", rinc1, 1);
            @(negedge clk);
            check("single_tvalid0", ax0.tvalid, 1);
            check("single_word0", p0, vecs[v].exp_word);
            check("single_pre_tvalid1", ax1.tvalid, 0);
            @(negedge clk);
            check("single_post_tvalid0", ax0.tvalid, 0);
            check("single_tvalid1", ax1.tvalid, 1);
            check("single_word1", p1, vecs[v].exp_word);
            @(posedge clk); #1;
            check("single_rincs0", 64'(rp0 - r0), 1);
            check("single_rincs1", 64'(rp1 - r1), 1);
        end
        drain("single", 10);

        // stream of 16 words with continuous tready
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) push({1'b0, 8'(i), 8'(i), 32'(i)});
        n0 = 0; n1 = 0; f0 = -1; f1 = -1; l0 = 0; l1 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ax0.tvalid && tready) begin
                if (f0 < 0) f0 = c;
                l0 = c;
                n0++;
            end
            if (ax1.tvalid && tready) begin
                if (f1 < 0) f1 = c;
                l1 = c;
                n1++;
            end
        end
        check("stream_n0", 64'(n0), 16);
        check("stream_n1", 64'(n1), 16);
        check("stream_span0", 64'(l0 - f0), 15);
        check("stream_span1", 64'(l1 - f1), 15);
        drain("stream", 10);

        // backpressure: exactly two words taken, head stable
        @(posedge clk); #1;
        tready = 1'b0;
        r0 = rp0;
        r1 = rp1;
        w0 = {1'b0, 8'h77, 8'h66, 32'hB000};
        push(w0);
        for (int i = 1; i < 8; i++) push({1'(i == 7), 8'h77, 8'h66, 32'hB000 + 32'(i)});
        repeat (10) @(posedge clk);
        #1;
        check("bp_rincs0", 64'(rp0 - r0), 2);
        check("bp_rincs1", 64'(rp1 - r1), 2);
        check("bp_tvalid0", ax0.tvalid, 1);
        check("bp_tvalid1", ax1.tvalid, 1);
        check("bp_head0", p0, w0);
        check("bp_head1", p1, w0);
        tready = 1'b1;
        drain("bp", 40);

        // random tready and FIFO empty toggling
        pushed = 0;
        for (int c = 0; c < 2000 && pushed < 64; c++) begin
            @(posedge clk); #1;
            tready = 1'($urandom % 2);
            hold = ($urandom % 4) == 0;
            if ($urandom % 2 == 1) begin
                push({1'($urandom % 2), 8'($urandom), 8'($urandom), 32'($urandom)});
                pushed++;
            end
        end
        repeat (20) begin
            @(posedge clk); #1;
            tready = 1'($urandom % 2);
            hold = ($urandom % 4) == 0;
        end
        hold = 1'b0;
        tready = 1'b1;
        drain("rand", 200);

        // reset while two words are held: those are dropped, the FIFO remainder follows
        @(posedge clk); #1;
        tready = 1'b0;
        for (int i = 0; i < 6; i++) push({1'b0, 8'h0C, 8'h0D, 32'hD000 + 32'(i)});
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_tvalid0", ax0.tvalid, 0);
        check("mid_tvalid1", ax1.tvalid, 0);
        check("mid_rinc0", rinc0, 0);
        check("mid_rinc1", rinc1, 0);
        rebuild();
        check("mid_remain0", 64'(exp0.size()), 4);
        check("mid_remain1", 64'(exp1.size()), 4);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tready = 1'b1;
        drain("mid", 30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
